// File: rtl/rca_ora.sv
// rca_ora: output response analyser for a 4-bit ripple-carry adder under test.
// Over 8 sample edges it compares the CUT response {cout,sum} with a
// reference sum, counts mismatches, remembers the first failing index, and
// compacts every response into a 5-bit MISR (x^5+x^2+1).
module rca_ora #(
  parameter logic [4:0] GOLDEN_SIG = 5'h17
) (
  input  logic       clk,
  input  logic       init,
  input  logic       test,
  input  logic [3:0] at,
  input  logic [3:0] bt,
  input  logic       cint,
  input  logic [3:0] sum,
  input  logic       cout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       fail,
  output logic [3:0] fail_count,
  output logic [2:0] first_fail,
  output logic [4:0] signature
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0] state_r;
  logic [2:0] pidx_r;
  logic [4:0] sig_r;
  logic [3:0] fcnt_r;
  logic [2:0] ffirst_r;
  logic       mis_seen_r;

  logic [4:0] exp_s;
  logic [4:0] d_s;
  logic       sample_s;
  logic       mismatch_s;

  // One MISR step: n0=s4^d0, n1=s0^d1, n2=s1^s4^d2, n3=s2^d3, n4=s3^d4.
  function automatic logic [4:0] misr_next(input logic [4:0] s, input logic [4:0] d);
    logic [4:0] n;
    n[0] = s[4] ^ d[0];
    n[1] = s[0] ^ d[1];
    n[2] = s[1] ^ s[4] ^ d[2];
    n[3] = s[2] ^ d[3];
    n[4] = s[3] ^ d[4];
    return n;
  endfunction

  // Reference sum, response word and sample/mismatch qualification for this edge.
  always_comb begin
    exp_s    = {1'b0, at} + {1'b0, bt} + {4'b0000, cint};
    d_s      = {cout, sum};
    sample_s = 1'b0;
    if ((state_r == ST_RUN) && test) begin
      sample_s = 1'b1;
    end else begin
      sample_s = 1'b0;
    end
    mismatch_s = sample_s && (d_s != exp_s);
  end

  // Session FSM, sample index, MISR and failure bookkeeping.
  always_ff @(posedge clk) begin
    if (init) begin
      state_r    <= ST_IDLE;
      pidx_r     <= 3'd0;
      sig_r      <= 5'd0;
      fcnt_r     <= 4'd0;
      ffirst_r   <= 3'd0;
      mis_seen_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (test) begin
            state_r <= ST_RUN;
            pidx_r  <= 3'd0;
          end
        end
        ST_RUN: begin
          if (sample_s) begin
            sig_r  <= misr_next(sig_r, d_s);
            pidx_r <= pidx_r + 3'd1;
            if (mismatch_s) begin
              fcnt_r     <= fcnt_r + 4'd1;
              mis_seen_r <= 1'b1;
              if (!mis_seen_r) begin
                ffirst_r <= pidx_r;
              end
            end
            if (pidx_r == 3'd7) begin
              state_r <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_DONE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    busy       = (state_r == ST_RUN);
    done       = (state_r == ST_DONE);
    fail       = mis_seen_r | (done & (sig_r != GOLDEN_SIG));
    pass       = done & ~fail;
    fail_count = fcnt_r;
    first_fail = ffirst_r;
    signature  = sig_r;
  end

endmodule

// File: tb/tb_rca_ora.sv
// tb_rca_ora: directed and randomized checks of rca_ora against a
// session-level reference model (polynomial MISR, sample counting).
module tb_rca_ora;

  logic       clk = 1'b0;
  logic       init, test, cint, cout;
  logic [3:0] at, bt, sum;

  logic       busy, done, pass, fail;
  logic [3:0] fail_count;
  logic [2:0] first_fail;
  logic [4:0] signature;

  logic       g_busy, g_done, g_pass, g_fail;
  logic [3:0] g_fail_count;
  logic [2:0] g_first_fail;
  logic [4:0] g_signature;

  always #5 clk = ~clk;

  rca_ora dut (
    .clk(clk), .init(init), .test(test), .at(at), .bt(bt), .cint(cint),
    .sum(sum), .cout(cout), .busy(busy), .done(done), .pass(pass),
    .fail(fail), .fail_count(fail_count), .first_fail(first_fail),
    .signature(signature)
  );

  rca_ora #(.GOLDEN_SIG(5'h00)) dut_g0 (
    .clk(clk), .init(init), .test(test), .at(at), .bt(bt), .cint(cint),
    .sum(sum), .cout(cout), .busy(g_busy), .done(g_done), .pass(g_pass),
    .fail(g_fail), .fail_count(g_fail_count), .first_fail(g_first_fail),
    .signature(g_signature)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int         m_phase;   // 0 idle, 1 run, 2 done
  int         m_n;
  int         m_fc;
  int         m_ff;
  bit         m_seen;
  logic [4:0] m_sig;

  logic [3:0] pat_a [8] = '{4'hA, 4'hA, 4'h5, 4'h5, 4'h0, 4'h0, 4'hF, 4'hF};
  logic [3:0] pat_b [8] = '{4'hA, 4'h5, 4'hA, 4'h5, 4'h0, 4'hF, 4'h0, 4'hF};
  logic       pat_c [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [4:0] sig_tab [8] = '{5'h15, 5'h00, 5'h0F, 5'h14, 5'h0D, 5'h0A, 5'h04, 5'h17};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // multiply signature by x modulo x^5+x^2+1, then add the response word
  function automatic logic [4:0] misr_ref(input logic [4:0] s, input logic [4:0] d);
    logic [5:0] t;
    t = {s, 1'b0};
    if (t[5]) t = t ^ 6'b100101;
    return t[4:0] ^ d;
  endfunction

  task automatic check_all();
    bit e_done, e_fail, e_gfail;
    e_done  = (m_phase == 2);
    e_fail  = m_seen || (e_done && (m_sig != 5'h17));
    e_gfail = m_seen || (e_done && (m_sig != 5'h00));
    chk("busy",       32'(busy),       32'(m_phase == 1));
    chk("done",       32'(done),       32'(e_done));
    chk("fail",       32'(fail),       32'(e_fail));
    chk("pass",       32'(pass),       32'(e_done && !e_fail));
    chk("fail_count", 32'(fail_count), 32'(m_fc));
    chk("first_fail", 32'(first_fail), 32'(m_ff));
    chk("signature",  32'(signature),  32'(m_sig));
    chk("g0_fail",    32'(g_fail),     32'(e_gfail));
    chk("g0_pass",    32'(g_pass),     32'(e_done && !e_gfail));
    chk("g0_done",    32'(g_done),     32'(e_done));
  endtask

  // fault: 0 correct adder, 1 sum[0] stuck-at-0, 2 random wrong response
  task automatic step(input logic i, input logic t, input logic [3:0] a,
                      input logic [3:0] b, input logic c, input int fault);
    logic [4:0] good, resp;
    good = 5'(a) + 5'(b) + 5'(c);
    resp = good;
    if (fault == 1) resp = good & 5'b11110;
    if (fault == 2) resp = good ^ 5'($urandom_range(1, 31));
    init = i; test = t; at = a; bt = b; cint = c;
    sum = resp[3:0]; cout = resp[4];
    @(posedge clk);
    if (i) begin
      m_phase = 0; m_n = 0; m_fc = 0; m_ff = 0; m_seen = 0; m_sig = 5'd0;
    end else if (m_phase == 0 && t) begin
      m_phase = 1; m_n = 0;
    end else if (m_phase == 1 && t) begin
      if (resp != good) begin
        if (!m_seen) m_ff = m_n;
        m_seen = 1;
        m_fc++;
      end
      m_sig = misr_ref(m_sig, resp);
      m_n++;
      if (m_n == 8) m_phase = 2;
    end
    #1;
    check_all();
  endtask

  task automatic junk(input logic t, input int fault);
    step(1'b0, t, 4'($urandom), 4'($urandom), 1'($urandom), fault);
  endtask

  initial begin
    init = 1'b1; test = 1'b0; at = 4'd0; bt = 4'd0; cint = 1'b0; sum = 4'd0; cout = 1'b0;
    m_phase = 0; m_n = 0; m_fc = 0; m_ff = 0; m_seen = 0; m_sig = 5'd0;

    // reset state
    step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sig",  32'(signature), 32'd0);

    // fault-free run with the documented MISR sequence
    step(1'b0, 1'b1, 4'd3, 4'd4, 1'b0, 2);   // entry edge takes no sample
    chk("entry_sig", 32'(signature), 32'd0);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, pat_a[k], pat_b[k], pat_c[k], 0);
      chk("misr_seq", 32'(signature), 32'(sig_tab[k]));
    end
    chk("ff_done", 32'(done), 32'd1);
    chk("ff_pass", 32'(pass), 32'd1);
    chk("g0_fail_golden", 32'(g_fail), 32'd1);

    // DONE hold with wrong responses and toggling test
    for (int k = 0; k < 10; k++) junk(1'($urandom), 2);
    chk("hold_sig",  32'(signature), 32'h17);
    chk("hold_pass", 32'(pass), 32'd1);

    // sum[0] stuck-at-0
    step(1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 0);
    step(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 0);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, pat_a[k], pat_b[k], pat_c[k], 1);
      if (k == 0) chk("sa0_fail_k0", 32'(fail), 32'd1);
    end
    chk("sa0_count", 32'(fail_count), 32'd4);
    chk("sa0_first", 32'(first_fail), 32'd0);
    chk("sa0_pass",  32'(pass), 32'd0);

    // pause after sample 3
    step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 0);
    step(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 0);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, pat_a[k], pat_b[k], pat_c[k], 0);
      if (k == 3) begin
        for (int p = 0; p < 3; p++) junk(1'b0, 2);
        chk("pause_sig", 32'(signature), 32'(sig_tab[3]));
      end
    end
    chk("pause_final", 32'(signature), 32'h17);
    chk("pause_pass",  32'(pass), 32'd1);

    // init at sample 5, then a clean rerun
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 0);
    step(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 0);
    step(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, pat_a[k], pat_b[k], pat_c[k], 2);
    step(1'b1, 1'b1, pat_a[5], pat_b[5], pat_c[5], 2);
    chk("midrst_sig",  32'(signature), 32'd0);
    chk("midrst_cnt",  32'(fail_count), 32'd0);
    chk("midrst_fail", 32'(fail), 32'd0);
    step(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 0);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, pat_a[k], pat_b[k], pat_c[k], 0);
    chk("rerun_sig",  32'(signature), 32'h17);
    chk("rerun_pass", 32'(pass), 32'd1);

    // randomized sessions
    for (int s = 0; s < 40; s++) begin
      step(1'b1, 1'($urandom), 4'd0, 4'd0, 1'b0, 0);
      for (int c = 0; c < 24; c++) begin
        int r;
        r = int'($urandom_range(0, 99));
        step(1'(r < 2), 1'(($urandom_range(0, 3)) != 0),
             4'($urandom), 4'($urandom), 1'($urandom),
             (($urandom_range(0, 4)) == 0) ? 2 : 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rca_ora.md
RCA_ORA -- requirements
Module: rca_ora

Interface
REQ-001 Parameter GOLDEN_SIG, default 5'h17, fault-free MISR signature after 8 patterns.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 init  input  1  reset, synchronous, active-high.
REQ-004 test  input  1  test enable; starts the session from IDLE and qualifies each sample in RUN.
REQ-005 at  input  4  A operand applied to the CUT adder.
REQ-006 bt  input  4  B operand applied to the CUT adder.
REQ-007 cint  input  1  carry-in applied to the CUT adder.
REQ-008 sum  input  4  CUT adder sum response.
REQ-009 cout  input  1  CUT adder carry-out response.
REQ-010 busy  output  1  high while in RUN.
REQ-011 done  output  1  high while in DONE.
REQ-012 pass  output  1  done and no failure.
REQ-013 fail  output  1  sticky failure flag.
REQ-014 fail_count  output  4  number of mismatching patterns, 0..8.
REQ-015 first_fail  output  3  sample index of the first mismatch.
REQ-016 signature  output  5  MISR contents.

Function
REQ-017 States: IDLE, RUN, DONE; encoding is free.
REQ-018 IDLE -> RUN on a posedge with test=1; this transition edge takes no sample.
REQ-019 RUN: each posedge with test=1 is one sample; test=0 holds all state (pause), no sample.
REQ-020 Sample index pidx (3 bits) = 0 at entry to RUN; it increments per sample.
REQ-021 The sample with pidx=7 moves RUN -> DONE on the same edge.
REQ-022 DONE holds all outputs until init; test is ignored in DONE.
REQ-023 Expected response exp[4:0] = at + bt + cint, computed as a 5-bit zero-extended sum; the response word is d[4:0] = {cout,sum}.
REQ-024 Mismatch = sample edge and d != exp, evaluated combinationally on the inputs present at that edge.
REQ-025 On a mismatch: fail_count increments by 1; if this is the first mismatch, first_fail <= pidx.
REQ-026 On every sample edge the MISR updates from d: n0=s4^d0, n1=s0^d1, n2=s1^s4^d2, n3=s2^d3, n4=s3^d4 (polynomial x^5+x^2+1).
REQ-027 fail = (a mismatch has been seen) | (done & signature != GOLDEN_SIG).
REQ-028 pass = done & ~fail; pass is never high outside DONE.
REQ-029 Outputs are registered or derived from registered state only; no input-to-output combinational path.
REQ-030 Input values outside sample edges (IDLE, paused RUN, DONE) have no effect.

Reset
REQ-031 init=1 at a posedge: state=IDLE, pidx=0, signature=0, fail_count=0, first_fail=0, mismatch flag=0, so busy=done=pass=fail=0.
REQ-032 init takes priority over test in every state, including mid-RUN and DONE.
REQ-033 After a mid-RUN init, the next session starts clean; no accumulated state is retained.

Verification
REQ-034 Fault-free run: init; test=1; apply patterns k=0..7 on the 8 sample edges (at/bt/cint = A/0xA/1, 0xA/5/0, 5/0xA/0, 5/5/0, 0/0/0, 0/0xF/1, 0xF/0/1, 0xF/0xF/1) with a correct adder -> MISR sequence 15,00,0F,14,0D,0A,04,17; done=1, signature=5'h17, fail_count=0, pass=1.
REQ-035 Same patterns with sum[0] stuck-at-0 -> mismatches at k=0,1,2,7; fail=1 after the k=0 sample edge; at done: fail_count=4, first_fail=0, pass=0.
REQ-036 Pause: drop test for 3 cycles after sample 3 -> pidx, signature and counts are frozen; the final results equal REQ-034.
REQ-037 Reset mid-run: init at sample 5 -> all outputs 0 on the next edge; a full rerun gives the REQ-034 results.
REQ-038 Correct sum/cout, but GOLDEN_SIG overridden to 5'h00 -> fail_count=0, done=1, fail=1, pass=0.
REQ-039 DONE hold: toggle test and drive a wrong sum for 10 cycles after done -> all outputs unchanged.
